// File: rtl/led_ctrl_pkg.sv
// Shared types and defaults for the LED rate controller: FSM states, mode
// encoding and the default per-mode divide ratios.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN
    } state_t;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF = 2'd0;

    localparam int unsigned DIV1_DEFAULT = 1000;
    localparam int unsigned DIV2_DEFAULT = 500;
    localparam int unsigned DIV3_DEFAULT = 200;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/led_rate_controller_if.sv
// Mode-select / LED-output signal bundle for the LED rate controller,
// with a master side (drives SW) and a slave side (the controller).
interface led_rate_controller_if;

    logic [1:0]  SW;
    logic [15:0] LD;
    logic        mode_clock;
    logic        tick;

    modport master (
        output SW,
        input  LD,
        input  mode_clock,
        input  tick
    );

    modport slave (
        input  SW,
        output LD,
        output mode_clock,
        output tick
    );

endinterface

// File: rtl/led_rate_controller_rate_divider.sv
// Free-running modulo counter: counts 0..limit, pulses wrap while at limit,
// and is forced to zero whenever clear is high.
module rate_divider #(
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clear,
    input  logic [W-1:0] limit,
    output logic         wrap
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign wrap = (cnt_q == limit);

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (clear || wrap) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_rate_controller.sv
// LED chaser: rotates a single lit LED left at one of three rates chosen by
// an asynchronous 2-bit switch; also emits a per-step tick and a square wave.
module led_rate_controller
    import led_ctrl_pkg::*;
#(
    parameter int unsigned DIV1        = DIV1_DEFAULT,
    parameter int unsigned DIV2        = DIV2_DEFAULT,
    parameter int unsigned DIV3        = DIV3_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        SCLK,
    input  logic        RSTN,
    input  logic [1:0]  SW,
    output logic [15:0] LD,
    output logic        mode_clock,
    output logic        tick
);

    localparam int unsigned DIV_MAX = max3(DIV1, DIV2, DIV3);
    localparam int unsigned CW      = $clog2(DIV_MAX);

    if (DIV1 < 2 || DIV2 < 2 || DIV3 < 2 || SYNC_STAGES < 2) begin : g_bad_param
        $error("led_rate_controller: DIVn must be >= 2 and SYNC_STAGES >= 2");
    end

    logic [SYNC_STAGES-1:0][1:0] sync_q, sync_d;
    state_t                      state_q, state_d;
    mode_t                       mode_q, mode_d;
    logic [15:0]                 ld_q, ld_d;
    logic                        mc_q, mc_d;
    logic                        tick_q, tick_d;
    mode_t                       sw_s;
    logic [CW-1:0]               limit;
    logic                        div_clear;
    logic                        div_wrap;

    // Stage 0 takes the raw switch; only the last stage is used by logic.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], SW};
    assign sw_s   = sync_q[SYNC_STAGES-1];

    always_comb begin
        case (mode_q)
            2'd1:    limit = CW'(DIV1 - 1);
            2'd2:    limit = CW'(DIV2 - 1);
            2'd3:    limit = CW'(DIV3 - 1);
            default: limit = '0;
        endcase
    end

    rate_divider #(
        .W(CW)
    ) u_div (
        .clk  (SCLK),
        .rstn (RSTN),
        .clear(div_clear),
        .limit(limit),
        .wrap (div_wrap)
    );

    // The divider only runs in a steady RUN cycle, so a mode change or switch-off
    // both suppresses the tick and restarts the count from zero.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        ld_d      = ld_q;
        mc_d      = mc_q;
        tick_d    = 1'b0;
        div_clear = 1'b1;
        case (state_q)
            ST_IDLE: begin
                ld_d = '0;
                mc_d = 1'b0;
                if (sw_s != MODE_OFF) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                mode_d  = sw_s;
                ld_d    = 16'h0001;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (sw_s == MODE_OFF) begin
                    state_d = ST_IDLE;
                    mode_d  = MODE_OFF;
                    ld_d    = '0;
                    mc_d    = 1'b0;
                end else if (sw_s != mode_q) begin
                    state_d = ST_LOAD;
                end else begin
                    div_clear = 1'b0;
                    if (div_wrap) begin
                        tick_d = 1'b1;
                        mc_d   = ~mc_q;
                        ld_d   = {ld_q[14:0], ld_q[15]};
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge SCLK) begin
        if (!RSTN) begin
            sync_q  <= '0;
            state_q <= ST_IDLE;
            mode_q  <= MODE_OFF;
            ld_q    <= '0;
            mc_q    <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            mode_q  <= mode_d;
            ld_q    <= ld_d;
            mc_q    <= mc_d;
            tick_q  <= tick_d;
        end
    end

    assign LD         = ld_q;
    assign mode_clock = mc_q;
    assign tick       = tick_q;

endmodule

// File: tb/tb_led_rate_controller.sv
// Bench for led_rate_controller: directed switch/reset sequences, an
// arithmetic reference model checked every cycle, plus literal spot checks.
module tb_led_rate_controller;

    localparam int unsigned P_DIV1 = 10;
    localparam int unsigned P_DIV2 = 7;
    localparam int unsigned P_DIV3 = 4;
    localparam int unsigned P_SYNC = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    led_rate_controller_if ifc();

    led_rate_controller #(
        .DIV1       (P_DIV1),
        .DIV2       (P_DIV2),
        .DIV3       (P_DIV3),
        .SYNC_STAGES(P_SYNC)
    ) dut (
        .SCLK      (clk),
        .RSTN      (rstn),
        .SW        (ifc.SW),
        .LD        (ifc.LD),
        .mode_clock(ifc.mode_clock),
        .tick      (ifc.tick)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ld(input logic [15:0] v, input int budget, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (ifc.LD === v) found = 1'b1;
        end
        chk(name, 32'(found), 32'd1);
    endtask

    // Reference model: the pattern is 1 << (ticks mod 16), where a tick falls
    // every DIVn cycles of uninterrupted RUN for the latched mode.
    int unsigned hist [P_SYNC];
    int          m_phase;
    int unsigned m_mode, m_runc, m_ticks;
    logic [15:0] exp_ld;
    logic        exp_mc, exp_tick;

    function automatic int unsigned div_of(input int unsigned m);
        case (m)
            1:       return P_DIV1;
            2:       return P_DIV2;
            default: return P_DIV3;
        endcase
    endfunction

    always @(posedge clk) begin
        int unsigned sws;
        exp_tick = 1'b0;
        if (!rstn) begin
            for (int i = 0; i < int'(P_SYNC); i++) hist[i] = 0;
            m_phase = 0;
            m_mode  = 0;
            m_runc  = 0;
            m_ticks = 0;
            exp_ld  = 16'h0000;
            exp_mc  = 1'b0;
        end else begin
            sws = hist[P_SYNC-1];
            for (int i = int'(P_SYNC) - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = 32'(ifc.SW);
            if (m_phase == 0) begin
                exp_ld = 16'h0000;
                exp_mc = 1'b0;
                if (sws != 0) m_phase = 1;
            end else if (m_phase == 1) begin
                m_mode  = sws;
                m_runc  = 0;
                m_ticks = 0;
                exp_ld  = 16'h0001;
                m_phase = 2;
            end else if (sws == 0) begin
                m_phase = 0;
                exp_ld  = 16'h0000;
                exp_mc  = 1'b0;
            end else if (sws != m_mode) begin
                m_phase = 1;
            end else begin
                m_runc++;
                if (m_runc % div_of(m_mode) == 0) begin
                    m_ticks++;
                    exp_tick = 1'b1;
                    exp_mc   = ~exp_mc;
                end
                exp_ld = 16'(32'h1 << (m_ticks % 16));
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_LD", 32'(ifc.LD), 32'(exp_ld));
            chk("model_mode_clock", 32'(ifc.mode_clock), 32'(exp_mc));
            chk("model_tick", 32'(ifc.tick), 32'(exp_tick));
        end
    end

    initial begin
        int   n_t;
        int   n_tog;
        bit   saw_top;
        logic prev_mc;

        ifc.SW = 2'd0;
        rstn   = 1'b0;
        cyc(3);
        chk_en = 1'b1;
        chk("reset_LD", 32'(ifc.LD), 32'h0);
        chk("reset_mode_clock", 32'(ifc.mode_clock), 32'h0);
        chk("reset_tick", 32'(ifc.tick), 32'h0);

        // First start in mode 1 straight out of reset.
        rstn   = 1'b1;
        ifc.SW = 2'd1;
        cyc(3);
        chk("A_in_load_LD", 32'(ifc.LD), 32'h0);
        cyc(1);
        chk("A_run_LD", 32'(ifc.LD), 32'h0001);
        chk("A_run_tick", 32'(ifc.tick), 32'h0);
        cyc(9);
        chk("A_pre_tick_LD", 32'(ifc.LD), 32'h0001);
        chk("A_pre_tick", 32'(ifc.tick), 32'h0);
        cyc(1);
        chk("A_tick", 32'(ifc.tick), 32'h1);
        chk("A_tick_LD", 32'(ifc.LD), 32'h0002);
        chk("A_tick_mode_clock", 32'(ifc.mode_clock), 32'h1);

        // Switch mode 1 -> 2 at LD=0010.
        wait_ld(16'h0010, 50, "B_wait_LD_0010");
        ifc.SW = 2'd2;
        cyc(4);
        chk("B_reload_LD", 32'(ifc.LD), 32'h0001);
        chk("B_reload_mode_clock", 32'(ifc.mode_clock), 32'h0);
        cyc(6);
        chk("B_pre_tick", 32'(ifc.tick), 32'h0);
        cyc(1);
        chk("B_tick", 32'(ifc.tick), 32'h1);
        chk("B_tick_LD", 32'(ifc.LD), 32'h0002);

        // Mode change landing exactly on the divider wrap edge.
        cyc(4);
        ifc.SW = 2'd3;
        cyc(3);
        chk("C_wrap_tick", 32'(ifc.tick), 32'h0);
        chk("C_wrap_LD", 32'(ifc.LD), 32'h0002);
        chk("C_wrap_mode_clock", 32'(ifc.mode_clock), 32'h1);
        cyc(1);
        chk("C_reload_LD", 32'(ifc.LD), 32'h0001);
        chk("C_reload_mode_clock", 32'(ifc.mode_clock), 32'h1);

        // 64 RUN cycles in mode 3: a full rotation including 8000 -> 0001.
        n_t     = 0;
        n_tog   = 0;
        saw_top = 1'b0;
        prev_mc = ifc.mode_clock;
        for (int i = 0; i < 64; i++) begin
            cyc(1);
            if (ifc.tick === 1'b1) n_t++;
            if (ifc.mode_clock !== prev_mc) n_tog++;
            prev_mc = ifc.mode_clock;
            if (ifc.LD === 16'h8000) saw_top = 1'b1;
        end
        chk("D_tick_count", 32'(n_t), 32'd16);
        chk("D_toggle_count", 32'(n_tog), 32'd16);
        chk("D_saw_8000", 32'(saw_top), 32'd1);
        chk("D_final_LD", 32'(ifc.LD), 32'h0001);

        // One-cycle reset on the wrap edge, switch already at mode 2.
        cyc(3);
        rstn   = 1'b0;
        ifc.SW = 2'd2;
        cyc(1);
        chk("E_rst_LD", 32'(ifc.LD), 32'h0);
        chk("E_rst_mode_clock", 32'(ifc.mode_clock), 32'h0);
        chk("E_rst_tick", 32'(ifc.tick), 32'h0);
        rstn = 1'b1;
        cyc(3);
        chk("E_in_load_LD", 32'(ifc.LD), 32'h0);
        cyc(1);
        chk("E_run_LD", 32'(ifc.LD), 32'h0001);

        // Switch off mid-RUN.
        wait_ld(16'h0002, 20, "F_wait_LD_0002");
        ifc.SW = 2'd0;
        n_t    = 0;
        for (int i = 0; i < 13; i++) begin
            cyc(1);
            if (ifc.tick !== 1'b0) n_t++;
        end
        chk("F_no_tick", 32'(n_t), 32'd0);
        chk("F_idle_LD", 32'(ifc.LD), 32'h0);
        chk("F_idle_mode_clock", 32'(ifc.mode_clock), 32'h0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_rate_controller.md
LED_RATE_CONTROLLER -- requirements
Module: led_rate_controller

Interface
REQ-001 Parameter DIV1, default 1000, SCLK cycles per tick in mode 1.
REQ-002 Parameter DIV2, default 500, SCLK cycles per tick in mode 2.
REQ-003 Parameter DIV3, default 200, SCLK cycles per tick in mode 3.
REQ-004 Parameter SYNC_STAGES, default 2, flops in the SW synchronizer (>=2).
REQ-005 SCLK  input  1  single system clock; all state updates on posedge SCLK.
REQ-006 RSTN  input  1  reset, synchronous, active-low.
REQ-007 SW  input  2  mode select, asynchronous to SCLK: 0=off, 1/2/3=DIV1/DIV2/DIV3.
REQ-008 LD  output  16  LED pattern, registered.
REQ-009 mode_clock  output  1  square wave, toggles once per tick, registered.
REQ-010 tick  output  1  one-cycle pulse marking each pattern step, registered.

Function
REQ-011 The block SHALL pass SW through a SYNC_STAGES-deep flop chain; only the synchronized value (sw_s) drives logic, so a SW change affects state SYNC_STAGES+1 cycles later.
REQ-012 The FSM SHALL have states IDLE, LOAD, RUN.
REQ-013 IDLE: LD=16'h0000, mode_clock=0, tick=0, divider held at 0; sw_s!=0 -> LOAD.
REQ-014 LOAD (exactly one cycle): latch active mode = sw_s, LD<=16'h0001, divider<=0, mode_clock unchanged; next state RUN.
REQ-015 RUN: a 10-bit divider SHALL count 0..DIVn-1 for the latched mode; in the cycle it equals DIVn-1 it SHALL wrap to 0 and register tick=1, mode_clock<=~mode_clock, LD<=rotate-left-by-1 of LD.
REQ-016 Rotation SHALL wrap: LD=16'h8000 becomes 16'h0001 on the next tick.
REQ-017 tick SHALL be 0 in every cycle except the one after the divider wrap; back-to-back ticks are impossible (DIVn>=2 enforced by elaboration check).
REQ-018 RUN with sw_s==0 -> IDLE next cycle; LD, mode_clock, divider cleared on entry.
REQ-019 RUN with sw_s!=0 and sw_s!=latched mode -> LOAD (pattern restarts at 16'h0001, new rate applies from divider=0).
REQ-020 If the divider wrap and a mode change occur in the same cycle, the mode change SHALL win: no tick, no rotation, no mode_clock toggle.
REQ-021 Divider width SHALL be $clog2(max(DIV1,DIV2,DIV3)); compare values sized to that width, no truncation.
REQ-022 No combinational path from SW to any output.

Reset
REQ-023 RSTN=0 sampled at posedge SCLK SHALL force state=IDLE, LD=0, mode_clock=0, tick=0, divider=0, latched mode=0, synchronizer flops=0.
REQ-024 Reset asserted mid-RUN SHALL take effect the same edge; no tick SHALL be emitted in that cycle.
REQ-025 After RSTN deasserts with SW already nonzero, LOAD SHALL be entered SYNC_STAGES+1 cycles later.

Structure
REQ-026 Package led_ctrl_pkg SHALL hold the FSM state enum, the 2-bit mode type, the MODE_OFF constant, and default DIV1..DIV3 values.
REQ-027 The divider SHALL be a sub-module rate_divider (inputs clk, rstn, clear, limit; output wrap pulse); the FSM and LD register stay in led_rate_controller.

Verification
REQ-028 Reset, SW=1, DIV1=10 -> LD=0001 after 3 cycles + LOAD; first tick 10 cycles into RUN; LD=0002, mode_clock=1.
REQ-029 SW=3, DIV3=4, run 64 cycles of RUN -> 16 ticks, LD returns to 16'h0001 (wrap 8000->0001 seen), mode_clock toggled 16 times.
REQ-030 RUN in mode 1 at LD=0010, switch SW to 2 -> LOAD within 3 cycles, LD=0001, next tick after exactly DIV2 cycles.
REQ-031 Mode change timed to land on divider=DIVn-1 -> tick stays 0, LD=0001, no mode_clock toggle.
REQ-032 SW=0 during RUN -> IDLE within 3 cycles, LD=0000, mode_clock=0, tick never asserts.
REQ-033 RSTN=0 for one cycle mid-RUN at divider=DIVn-1 -> no tick, all outputs 0 next cycle; with SW held at 2 -> LOAD 3 cycles after release.
